// File: rtl/change_monitor.sv
// rtl/change_monitor.sv - logs {value, timestamp} records of a watched bus on every change into a show-ahead FIFO
module change_monitor #(
    parameter int W     = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [W-1:0]               sig_in,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [W-1:0]               evt_value,
    output logic [TS_W-1:0]            evt_time,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       ovf,
    input  logic                       ovf_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             armed_q, armed_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     val_mem_q  [DEPTH];
    logic [TS_W-1:0]  time_mem_q [DEPTH];

    logic push_req, pop, full, push_ok, drop;

    always_comb begin
        push_req = armed_q || (sig_in != prev_q);
        pop      = (count_q != '0) && evt_ready;
        full     = (count_q == CNT_W'(DEPTH));
        // A full FIFO still accepts a push when the head leaves at the same edge.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        ts_d     = ts_q + TS_W'(1);
        prev_d   = sig_in;
        armed_d  = 1'b0;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q     <= '0;
            prev_q   <= '0;
            armed_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            val_mem_q[wr_ptr_q]  <= sig_in;
            time_mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_value = val_mem_q[rd_ptr_q];
    assign evt_time  = time_mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_change_monitor.sv
// tb/tb_change_monitor.sv - randomized self-checking bench for change_monitor against a queue-based log model
module tb_change_monitor;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sig_in;
    logic       evt_ready;
    logic       ovf_clr;

    logic        evt_valid,  evt_valid4;
    logic [3:0]  evt_value,  evt_value4;
    logic [15:0] evt_time;
    logic [3:0]  evt_time4;
    logic [3:0]  evt_count,  evt_count4;
    logic        ovf,        ovf4;

    change_monitor #(.W(4), .TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_value(evt_value), .evt_time(evt_time),
        .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    change_monitor #(.W(4), .TS_W(4), .DEPTH(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in),
        .evt_valid(evt_valid4), .evt_ready(evt_ready),
        .evt_value(evt_value4), .evt_time(evt_time4),
        .evt_count(evt_count4), .ovf(ovf4), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        int         ts;
    } rec_t;

    rec_t       log_q[$];
    int         cyc_m;
    logic [3:0] last_m;
    bit         first_m;
    bit         ovf_m;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The log model: a record per cycle in which the bus differs from last cycle,
    // plus one unconditional record on the first cycle after reset.
    task automatic model_edge();
        bit want, take, full;
        rec_t r;
        if (!reset_n) begin
            log_q.delete();
            cyc_m   = 0;
            last_m  = 4'h0;
            first_m = 1'b1;
            ovf_m   = 1'b0;
            return;
        end
        want = first_m || (sig_in != last_m);
        take = (log_q.size() > 0) && evt_ready;
        full = (log_q.size() == 8);
        if (take) void'(log_q.pop_front());
        if (want && full && !take) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;
        if (want && (!full || take)) begin
            r.val = sig_in;
            r.ts  = cyc_m;
            log_q.push_back(r);
        end
        cyc_m++;
        last_m  = sig_in;
        first_m = 1'b0;
    endtask

    task automatic check_outputs();
        chk("evt_valid", 32'(evt_valid), 32'(log_q.size() > 0));
        chk("evt_count", 32'(evt_count), 32'(log_q.size()));
        chk("ovf", 32'(ovf), 32'(ovf_m));
        chk("evt_valid4", 32'(evt_valid4), 32'(log_q.size() > 0));
        chk("evt_count4", 32'(evt_count4), 32'(log_q.size()));
        chk("ovf4", 32'(ovf4), 32'(ovf_m));
        if (log_q.size() > 0) begin
            chk("evt_value", 32'(evt_value), 32'(log_q[0].val));
            chk("evt_time", 32'(evt_time), 32'(log_q[0].ts % 65536));
            chk("evt_value4", 32'(evt_value4), 32'(log_q[0].val));
            chk("evt_time4", 32'(evt_time4), 32'(log_q[0].ts % 16));
        end
    endtask

    task automatic cyc(input logic rst_n, input logic [3:0] s, input logic rdy, input logic clr);
        reset_n   = rst_n;
        sig_in    = s;
        evt_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        logic [3:0] s;
        // Reset, then a quiet bus: exactly one initial record.
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cyc(1'b1, 4'h0, 1'b0, 1'b0);
        chk("quiet_count", 32'(evt_count), 32'd1);

        // Changes at edges 5 and 9, consumer always ready.
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            s = (i < 5) ? 4'h0 : (i < 9) ? 4'h1 : 4'h3;
            cyc(1'b1, s, 1'b1, 1'b0);
        end

        // Overflow: toggle every cycle with no consumer.
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, (i % 2 == 0) ? 4'h0 : 4'hA, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("full_count", 32'(evt_count), 32'd8);
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(ovf), 32'd0);
        // Full FIFO: pop and push at the same edge, no drop.
        cyc(1'b1, 4'h5, 1'b1, 1'b0);
        chk("full_pushpop_ovf", 32'(ovf), 32'd0);
        chk("full_pushpop_count", 32'(evt_count), 32'd8);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'h5, 1'b1, 1'b0);

        // Wrap of the 4-bit timestamp and reset with records held.
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, (i == 17) ? 4'h7 : (i > 17 ? 4'h7 : 4'h0), (i < 17), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 1), 1'b0, 1'b0);
        cyc(1'b0, 4'h9, 1'b0, 1'b0);
        chk("rst_count", 32'(evt_count), 32'd0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        chk("rst_first_time", 32'(evt_time), 32'd0);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s = 4'($urandom);
            cyc(($urandom_range(0, 299) != 0), s, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
